// File: rtl/axi_decerr_slave_pkg.sv
// axi_decerr_slave_pkg: DECERR constants and FSM state types for the decode-error slave
package axi_decerr_slave_pkg;
    localparam logic [1:0]  RESP_DECERR       = 2'b11;
    localparam logic [63:0] RESP_DATA_DEFAULT = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [31:0] ERR_CNT_MAX       = 32'hFFFF_FFFF;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {31'b0, b};
        return s[32] ? ERR_CNT_MAX : s[31:0];
    endfunction
endpackage

// File: rtl/axi_decerr_slave.sv
// axi_decerr_slave: answers every AXI access with DECERR and logs the offending address
module axi_decerr_slave
    import axi_decerr_slave_pkg::*;
#(
    parameter int unsigned IdWidth   = 5,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter logic [DataWidth-1:0] RespData = DataWidth'(RESP_DATA_DEFAULT)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    input  logic                 err_clr_i,
    output logic [31:0]          err_cnt_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic                 err_write_o
);
    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    logic [IdWidth-1:0]   b_id_q, r_id_q;
    logic [7:0]           len_q, beat_q;
    logic [31:0]          err_cnt_q;
    logic [AddrWidth-1:0] err_addr_q;
    logic                 err_write_q;
    logic                 aw_hs, ar_hs, w_hs_last, b_hs, r_hs;
    logic [1:0]           err_inc;

    // readies depend on state only, so no valid->ready combinational path exists
    always_comb begin
        aw_ready_o = w_state_q == W_IDLE;
        w_ready_o  = w_state_q == W_DATA;
        b_valid_o  = w_state_q == W_RESP;
        b_id_o     = b_id_q;
        b_resp_o   = RESP_DECERR;
        aw_hs      = aw_ready_o && aw_valid_i;
        w_hs_last  = w_ready_o && w_valid_i && w_last_i;
        b_hs       = b_valid_o && b_ready_i;
        w_state_d  = aw_hs ? W_DATA : w_hs_last ? W_RESP : b_hs ? W_IDLE : w_state_q;
    end

    always_comb begin
        ar_ready_o = r_state_q == R_IDLE;
        r_valid_o  = r_state_q == R_DATA;
        r_id_o     = r_id_q;
        r_data_o   = RespData;
        r_resp_o   = RESP_DECERR;
        r_last_o   = r_valid_o && (beat_q == len_q);
        ar_hs      = ar_ready_o && ar_valid_i;
        r_hs       = r_valid_o && r_ready_i;
        r_state_d  = ar_hs ? R_DATA : (r_hs && r_last_o) ? R_IDLE : r_state_q;
        err_inc    = {1'b0, aw_hs} + {1'b0, ar_hs};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            b_id_q      <= '0;
            r_id_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            err_cnt_q   <= '0;
            err_addr_q  <= '0;
            err_write_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            if (aw_hs) b_id_q <= aw_id_i;
            if (ar_hs) begin
                r_id_q <= ar_id_i;
                len_q  <= ar_len_i;
            end
            beat_q    <= ar_hs ? 8'd0 : r_hs ? beat_q + 8'd1 : beat_q;
            err_cnt_q <= err_clr_i ? 32'd0 : sat_add(err_cnt_q, err_inc);
            // a write wins the log slot when both channels accept together
            if (aw_hs || ar_hs) begin
                err_addr_q  <= aw_hs ? aw_addr_i : ar_addr_i;
                err_write_q <= aw_hs;
            end
        end
    end

    assign err_cnt_o   = err_cnt_q;
    assign err_addr_o  = err_addr_q;
    assign err_write_o = err_write_q;
endmodule
